// File: rtl/me_pkg.sv
// Shared types for the motion-estimation scan controller: FSM states and
// the SPR mux select encodings driven into the PE array.
package me_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        SCAN = 2'd2,
        DONE = 2'd3
    } scan_state_t;

    localparam logic [1:0] SEL_DOWN = 2'd0;
    localparam logic [1:0] SEL_UP   = 2'd1;
    localparam logic [1:0] SEL_LEFT = 2'd2;
    localparam logic [1:0] SEL_ZERO = 2'd3;

endpackage

// File: rtl/me_mv_stepper.sv
// Serpentine motion-vector counter: walks (mv_x, mv_y) down even columns and
// up odd columns, stepping left at column ends; reports the shift for the next move.
module me_mv_stepper
    import me_pkg::*;
#(
    parameter int SEARCH_RANGE = 8,
    localparam int MV_W = $clog2(SEARCH_RANGE + 1) + 1
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    step,
    input  logic                    hold,
    output logic signed [MV_W-1:0]  mv_x,
    output logic signed [MV_W-1:0]  mv_y,
    output logic [1:0]              sel,
    output logic                    last
);

    localparam logic signed [MV_W-1:0] SR_POS = MV_W'(SEARCH_RANGE);
    localparam logic signed [MV_W-1:0] SR_NEG = -SR_POS;
    localparam logic SR_ODD = (SEARCH_RANGE % 2) == 1;

    logic signed [MV_W-1:0] mv_x_q, mv_x_d;
    logic signed [MV_W-1:0] mv_y_q, mv_y_d;
    logic                   col_odd;
    logic                   col_end;

    // Column index is mv_x + SR, so its parity is mv_x[0] xor SR[0].
    always_comb begin
        col_odd = mv_x_q[0] ^ SR_ODD;
        col_end = col_odd ? (mv_y_q == SR_NEG) : (mv_y_q == SR_POS);
        last    = (mv_x_q == SR_POS) && (mv_y_q == SR_POS);

        sel = SEL_DOWN;
        if (!last) begin
            if (col_end) begin
                sel = SEL_LEFT;
            end else if (col_odd) begin
                sel = SEL_UP;
            end
        end
    end

    always_comb begin
        mv_x_d = mv_x_q;
        mv_y_d = mv_y_q;
        if (step && !hold) begin
            if (last) begin
                mv_x_d = SR_NEG;
                mv_y_d = SR_NEG;
            end else if (col_end) begin
                mv_x_d = mv_x_q + MV_W'(1);
            end else if (col_odd) begin
                mv_y_d = mv_y_q - MV_W'(1);
            end else begin
                mv_y_d = mv_y_q + MV_W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mv_x_q <= SR_NEG;
            mv_y_q <= SR_NEG;
        end else begin
            mv_x_q <= mv_x_d;
            mv_y_q <= mv_y_d;
        end
    end

    assign mv_x = mv_x_q;
    assign mv_y = mv_y_q;

endmodule

// File: rtl/me_scan_ctrl.sv
// Full-search ME sequencer: loads CPR/SPR rows, then serpentine-scans the
// search window issuing one tagged candidate per cycle. Optional macro: ME_STALL_EN.
module me_scan_ctrl
    import me_pkg::*;
#(
    parameter int MACRO_DIM    = 16,
    parameter int SEARCH_RANGE = 8,
    localparam int MV_W  = $clog2(SEARCH_RANGE + 1) + 1,
    localparam int ROW_W = $clog2(MACRO_DIM)
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    start,
`ifdef ME_STALL_EN
    input  logic                    stall,
`endif
    output logic                    busy,
    output logic                    done,
    output logic                    en_cpr,
    output logic                    en_spr,
    output logic [1:0]              sel,
    output logic [ROW_W-1:0]        load_row,
    output logic                    cand_valid,
    output logic signed [MV_W-1:0]  mv_x,
    output logic signed [MV_W-1:0]  mv_y
);

    localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(MACRO_DIM - 1);

    scan_state_t      state_q, state_d;
    logic [ROW_W-1:0] row_q, row_d;
    logic             stall_w;
    logic             step_sel_last;
    logic [1:0]       step_sel;

`ifdef ME_STALL_EN
    assign stall_w = stall;
`else
    assign stall_w = 1'b0;
`endif

    me_mv_stepper #(
        .SEARCH_RANGE (SEARCH_RANGE)
    ) u_stepper (
        .clk   (clk),
        .rst_n (rst_n),
        .step  (state_q == SCAN),
        .hold  (stall_w),
        .mv_x  (mv_x),
        .mv_y  (mv_y),
        .sel   (step_sel),
        .last  (step_sel_last)
    );

    always_comb begin
        state_d = state_q;
        row_d   = row_q;
        if (!stall_w) begin
            case (state_q)
                IDLE: begin
                    if (start) begin
                        state_d = LOAD;
                    end
                end
                LOAD: begin
                    if (row_q == ROW_LAST) begin
                        state_d = SCAN;
                        row_d   = '0;
                    end else begin
                        row_d = row_q + ROW_W'(1);
                    end
                end
                SCAN: begin
                    if (step_sel_last) begin
                        state_d = DONE;
                    end
                end
                DONE: begin
                    state_d = IDLE;
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            row_q   <= '0;
        end else begin
            state_q <= state_d;
            row_q   <= row_d;
        end
    end

    // Stall gates only the strobes; sel keeps pointing at the pending shift.
    always_comb begin
        busy       = (state_q != IDLE);
        done       = (state_q == DONE) && !stall_w;
        en_cpr     = (state_q == LOAD) && !stall_w;
        en_spr     = ((state_q == LOAD) || ((state_q == SCAN) && !step_sel_last)) && !stall_w;
        cand_valid = (state_q == SCAN) && !stall_w;
        sel        = (state_q == SCAN) ? step_sel : SEL_DOWN;
        load_row   = row_q;
    end

endmodule

// File: tb/tb_me_scan_ctrl.sv
// Self-checking bench for me_scan_ctrl (MACRO_DIM=4, SEARCH_RANGE=2) against a
// progress-counter reference model and a precomputed serpentine candidate list.
module tb_me_scan_ctrl;

    localparam int MD    = 4;
    localparam int SR    = 2;
    localparam int V     = 2 * SR + 1;
    localparam int N     = V * V;
    localparam int MV_W  = $clog2(SR + 1) + 1;
    localparam int ROW_W = $clog2(MD);
`ifdef ME_STALL_EN
    localparam bit STALL_ON = 1'b1;
`else
    localparam bit STALL_ON = 1'b0;
`endif

    logic                   clk = 1'b0;
    logic                   rst_n = 1'b0;
    logic                   start = 1'b0;
    logic                   stall = 1'b0;
    logic                   busy, done, en_cpr, en_spr, cand_valid;
    logic [1:0]             sel;
    logic [ROW_W-1:0]       load_row;
    logic signed [MV_W-1:0] mv_x, mv_y;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;
    int p       = -1;   // -1 idle, 0..MD-1 load, MD..MD+N-1 scan, MD+N done
    int cx[N];
    int cy[N];
    int csel[N];
    int done_cyc;
    int done_cnt;
    bit seen[V][V];

    always #5 clk = ~clk;

    me_scan_ctrl #(
        .MACRO_DIM    (MD),
        .SEARCH_RANGE (SR)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
`ifdef ME_STALL_EN
        .stall      (stall),
`endif
        .busy       (busy),
        .done       (done),
        .en_cpr     (en_cpr),
        .en_spr     (en_spr),
        .sel        (sel),
        .load_row   (load_row),
        .cand_valid (cand_valid),
        .mv_x       (mv_x),
        .mv_y       (mv_y)
    );

    task automatic check_eq(input string tag, input int got, input int exp);
        n_tests++;
        if (got != exp) begin
            n_fail++;
            $display("FAIL %s @cyc %0d: got %0d expected %0d", tag, cyc, got, exp);
        end
    endtask

    task automatic check_outputs(input string ph);
        bit in_load = (p >= 0) && (p < MD);
        bit in_scan = (p >= MD) && (p < MD + N);
        bit in_done = (p == MD + N);
        bit act     = !stall;
        int j       = p - MD;
        check_eq({ph, ".busy"},     int'(busy),       int'(p >= 0));
        check_eq({ph, ".done"},     int'(done),       int'(in_done && act));
        check_eq({ph, ".en_cpr"},   int'(en_cpr),     int'(in_load && act));
        check_eq({ph, ".en_spr"},   int'(en_spr),     int'((in_load || (in_scan && j != N - 1)) && act));
        check_eq({ph, ".cand"},     int'(cand_valid), int'(in_scan && act));
        check_eq({ph, ".sel"},      int'(sel),        in_scan ? csel[j] : 0);
        check_eq({ph, ".load_row"}, int'(load_row),   in_load ? p : 0);
        check_eq({ph, ".mv_x"},     int'(mv_x),       in_scan ? cx[j] : -SR);
        check_eq({ph, ".mv_y"},     int'(mv_y),       in_scan ? cy[j] : -SR);
    endtask

    task automatic tick(input string ph, input logic s, input logic st);
        @(negedge clk);
        start = s;
        stall = st & STALL_ON;
        #1;
        check_outputs(ph);
        if (done) begin
            done_cnt++;
            done_cyc = cyc;
        end
        if (cand_valid && mv_x >= -SR && mv_x <= SR && mv_y >= -SR && mv_y <= SR)
            seen[int'(mv_x) + SR][int'(mv_y) + SR] = 1'b1;
        @(posedge clk);
        if (rst_n && !stall) begin
            if (p < 0) begin
                if (start) p = 0;
            end else if (p == MD + N) begin
                p = -1;
            end else begin
                p++;
            end
        end
        cyc++;
    endtask

    task automatic apply_reset();
        @(negedge clk);
        rst_n = 1'b0;
        start = 1'b0;
        stall = 1'b0;
        #1;
        p = -1;
        check_outputs("arst");
        @(posedge clk);
        #2;
        rst_n = 1'b1;
    endtask

    task automatic new_run();
        cyc      = 0;
        done_cnt = 0;
        done_cyc = -1;
        foreach (seen[a, b]) seen[a][b] = 1'b0;
    endtask

    initial begin
        int k = 0;
        int uniq;
        // Serpentine candidate order and the shift that leads to each successor.
        for (int c = 0; c < V; c++) begin
            for (int r = 0; r < V; r++) begin
                cx[k] = c - SR;
                cy[k] = (c % 2 == 0) ? (-SR + r) : (SR - r);
                k++;
            end
        end
        for (int i = 0; i < N; i++) begin
            if (i == N - 1)            csel[i] = 0;
            else if (cx[i+1] != cx[i]) csel[i] = 2;
            else if (cy[i+1] > cy[i])  csel[i] = 0;
            else                       csel[i] = 1;
        end

        repeat (2) @(posedge clk);
        @(negedge clk);
        #1;
        check_outputs("reset");
        rst_n = 1'b1;

        // Single clean run.
        new_run();
        tick("run1", 1'b1, 1'b0);
        repeat (MD + N + 2) tick("run1", 1'b0, 1'b0);
        check_eq("run1.done_cnt", done_cnt, 1);
        check_eq("run1.done_cyc", done_cyc, MD + N + 1);
        uniq = 0;
        foreach (seen[a, b]) uniq += int'(seen[a][b]);
        check_eq("run1.unique_mv", uniq, N);

        // Starts while busy are ignored.
        new_run();
        for (int i = 0; i < MD + N + 3; i++)
            tick("run2", (i == 0) || (i == 3) || (i == 20), 1'b0);
        check_eq("run2.done_cnt", done_cnt, 1);

        // Reset in mid-scan, then a fresh run.
        new_run();
        for (int i = 0; i < 12; i++) tick("run3", i == 0, 1'b0);
        apply_reset();
        check_eq("run3.no_done", done_cnt, 0);
        new_run();
        tick("run3b", 1'b1, 1'b0);
        repeat (MD + N + 2) tick("run3b", 1'b0, 1'b0);
        check_eq("run3b.done_cnt", done_cnt, 1);
        check_eq("run3b.done_cyc", done_cyc, MD + N + 1);

        // Start held high relaunches back to back.
        new_run();
        repeat (64) tick("run4", 1'b1, 1'b0);
        check_eq("run4.done_cnt", done_cnt, 2);
        for (int i = 0; i < MD + N + 3; i++) tick("run4t", 1'b0, 1'b0);

`ifdef ME_STALL_EN
        new_run();
        for (int i = 0; i < MD + N + 6; i++)
            tick("stall", i == 0, (i >= 10) && (i <= 12));
        check_eq("stall.done_cyc", done_cyc, MD + N + 4);
        check_eq("stall.done_cnt", done_cnt, 1);
`endif

        // Randomized starts, stalls and one asynchronous reset.
        for (int r = 0; r < 6; r++) begin
            new_run();
            for (int i = 0; i < 90; i++) begin
                if (r == 2 && i == 40) apply_reset();
                tick("rand", $urandom_range(0, 7) == 0, $urandom_range(0, 4) == 0);
            end
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
